// File: rtl/fpdiv_pkg.sv
// Shared types and multiplier-select encodings for the Goldschmidt divide sequencer.
// The select values must match the operand mux wiring inside the fpdiv datapath.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_A = 3'd1,
    S_INIT_B = 3'd2,
    S_ITER_A = 3'd3,
    S_ITER_B = 3'd4,
    S_REM    = 3'd5,
    S_CAPT   = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  localparam logic [1:0] MUX4_NUM_IA = 2'b00;
  localparam logic [1:0] MUX4_DEN_IA = 2'b01;
  localparam logic [1:0] MUX4_NUM_C  = 2'b10;
  localparam logic [1:0] MUX4_DEN_C  = 2'b11;

  localparam logic [1:0] MUX3_IA  = 2'b00;
  localparam logic [1:0] MUX3_C   = 2'b01;
  localparam logic [1:0] MUX3_REM = 2'b10;

  typedef struct packed {
    logic [1:0] sel_mux4;
    logic [1:0] sel_mux3;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{sel_mux4: MUX4_NUM_IA, sel_mux3: MUX3_IA,
                                  en_a: 1'b0, en_b: 1'b0, en_rem: 1'b0};

endpackage

// File: rtl/fpdiv_seq_ctrl.sv
// Moore sequencer that accepts one divide, steps the fpdiv multiply schedule and
// returns the captured quotient on a valid/ready handshake.
module fpdiv_seq_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERATIONS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_num,
  input  logic [31:0] op_denom,
  input  logic        op_rm,
  output logic [31:0] dp_num,
  output logic [31:0] dp_denom,
  output logic        dp_rm,
  output logic [1:0]  sel_mux4,
  output logic [1:0]  sel_mux3,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  input  logic [31:0] dp_final_ans,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
);

  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITERATIONS);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  ctrl_t            ctrl;
  logic             accept;

  assign accept  = (state == S_IDLE) && op_valid;
  assign cnt_inc = cnt + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:   state_next = op_valid ? S_INIT_A : S_IDLE;
      S_INIT_A: state_next = S_INIT_B;
      S_INIT_B: state_next = (ITERATIONS == 1) ? S_REM : S_ITER_A;
      S_ITER_A: state_next = S_ITER_B;
      S_ITER_B: state_next = (cnt_inc == ITER_LAST) ? S_REM : S_ITER_A;
      S_REM:    state_next = S_CAPT;
      S_CAPT:   state_next = S_RESP;
      S_RESP:   state_next = res_ready ? S_IDLE : S_RESP;
      default:  state_next = S_IDLE;
    endcase
  end

  // All datapath controls decode from the state register alone.
  always_comb begin
    ctrl      = CTRL_IDLE;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
      end
      S_INIT_A: begin
        ctrl.sel_mux4 = MUX4_NUM_IA;
        ctrl.sel_mux3 = MUX3_IA;
        ctrl.en_a     = 1'b1;
      end
      S_INIT_B: begin
        ctrl.sel_mux4 = MUX4_DEN_IA;
        ctrl.sel_mux3 = MUX3_IA;
        ctrl.en_b     = 1'b1;
      end
      S_ITER_A: begin
        ctrl.sel_mux4 = MUX4_NUM_C;
        ctrl.sel_mux3 = MUX3_C;
        ctrl.en_a     = 1'b1;
      end
      S_ITER_B: begin
        ctrl.sel_mux4 = MUX4_DEN_C;
        ctrl.sel_mux3 = MUX3_C;
        ctrl.en_b     = 1'b1;
      end
      S_REM: begin
        ctrl.sel_mux4 = MUX4_NUM_C;
        ctrl.sel_mux3 = MUX3_REM;
        ctrl.en_rem   = 1'b1;
      end
      S_CAPT: begin
        ctrl.sel_mux4 = MUX4_NUM_C;
        ctrl.sel_mux3 = MUX3_REM;
      end
      S_RESP: begin
        res_valid = 1'b1;
      end
      default: begin
        ctrl     = CTRL_IDLE;
        op_ready = 1'b1;
        busy     = 1'b0;
      end
    endcase
  end

  assign sel_mux4 = ctrl.sel_mux4;
  assign sel_mux3 = ctrl.sel_mux3;
  assign en_a     = ctrl.en_a;
  assign en_b     = ctrl.en_b;
  assign en_rem   = ctrl.en_rem;

  // Operands are only written on accept, so they stay fixed for the whole schedule.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      dp_num   <= '0;
      dp_denom <= '0;
      dp_rm    <= 1'b0;
      res_data <= '0;
    end else begin
      if (accept) begin
        dp_num   <= op_num;
        dp_denom <= op_denom;
        dp_rm    <= op_rm;
        cnt      <= CNT_W'(1);
      end
      if (state == S_ITER_B) begin
        cnt <= cnt_inc;
      end
      if (state == S_CAPT) begin
        res_data <= dp_final_ans;
      end
    end
  end

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Directed bench for fpdiv_seq_ctrl; a small stub stands in for the fpdiv datapath
// and presents the quotient on final_ans only in the cycle after the remainder load.
module tb_fpdiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_num;
  logic [31:0] op_denom;
  logic        op_rm;
  logic [31:0] dp_num;
  logic [31:0] dp_denom;
  logic        dp_rm;
  logic [1:0]  sel_mux4;
  logic [1:0]  sel_mux3;
  logic        en_a;
  logic        en_b;
  logic        en_rem;
  logic [31:0] final_ans = 32'hDEAD_BEEF;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [6:0]  ctrl_obs;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] trace [14];

  fpdiv_seq_ctrl #(.ITERATIONS(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_num       (op_num),
    .op_denom     (op_denom),
    .op_rm        (op_rm),
    .dp_num       (dp_num),
    .dp_denom     (dp_denom),
    .dp_rm        (dp_rm),
    .sel_mux4     (sel_mux4),
    .sel_mux3     (sel_mux3),
    .en_a         (en_a),
    .en_b         (en_b),
    .en_rem       (en_rem),
    .dp_final_ans (final_ans),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {sel_mux4, sel_mux3, en_a, en_b, en_rem};

  function automatic logic [31:0] quot(input logic [31:0] n, input logic [31:0] d);
    case ({n, d})
      {32'h4040_0000, 32'h4000_0000}: return 32'h3FC0_0000;  // 3 / 2 = 1.5
      {32'h40C0_0000, 32'h4040_0000}: return 32'h4000_0000;  // 6 / 3 = 2
      {32'h4110_0000, 32'h4040_0000}: return 32'h4040_0000;  // 9 / 3 = 3
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h3F80_0000;  // 1 / 1 = 1
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) final_ans <= en_rem ? quot(dp_num, dp_denom) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int          lat;
    int          acc_t[$];
    logic [31:0] res_q[$];
    logic        prev_ready;
    logic        saw_valid;

    trace[0]  = 7'b00_00_100;
    trace[1]  = 7'b01_00_010;
    for (int k = 0; k < 5; k++) begin
      trace[2 + 2*k] = 7'b10_01_100;
      trace[3 + 2*k] = 7'b11_01_010;
    end
    trace[12] = 7'b10_10_001;
    trace[13] = 7'b10_10_000;

    // Reset held with a pending request: nothing may be accepted.
    reset     = 1'b0;
    op_valid  = 1'b1;
    op_num    = 32'h4040_0000;
    op_denom  = 32'h4000_0000;
    op_rm     = 1'b1;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("rst_op_ready", op_ready, 1'b1);
      check_bit("rst_res_valid", res_valid, 1'b0);
      check("rst_ctrl", 32'(ctrl_obs), 32'h0);
    end
    check("rst_dp_num", dp_num, 32'h0);
    check_bit("rst_dp_rm", dp_rm, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check_bit("rst_busy", busy, 1'b0);

    // Control trace for one op; res_ready held high early to show it is ignored.
    reset     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_bit("acc_op_ready", op_ready, 1'b0);
        check_bit("acc_busy", busy, 1'b1);
        op_valid = 1'b0;
        op_num   = 32'hFFFF_FFFF;
        op_rm    = 1'b0;
      end
      check($sformatf("trace_%0d", i), 32'({res_valid, ctrl_obs}), 32'({1'b0, trace[i]}));
      if (i == 13) res_ready = 1'b0;
    end
    check("hold_dp_num", dp_num, 32'h4040_0000);
    check("hold_dp_denom", dp_denom, 32'h4000_0000);
    check_bit("hold_dp_rm", dp_rm, 1'b1);
    @(negedge clk);
    check_bit("lat_res_valid", res_valid, 1'b1);
    check("res_3_div_2", res_data, 32'h3FC0_0000);

    // Backpressure with a competing request.
    op_valid = 1'b1;
    op_num   = 32'h40C0_0000;
    op_denom = 32'h4040_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_bit("bp_res_valid", res_valid, 1'b1);
      check("bp_res_data", res_data, 32'h3FC0_0000);
      check_bit("bp_op_ready", op_ready, 1'b0);
    end
    check("bp_no_accept", dp_num, 32'h4040_0000);
    res_ready = 1'b1;
    @(negedge clk);
    check_bit("rel_res_valid", res_valid, 1'b0);
    check_bit("rel_op_ready", op_ready, 1'b1);

    // Back-to-back ops with op_valid and res_ready held high.
    prev_ready = 1'b1;
    for (int c = 1; c <= 60 && res_q.size() < 2; c++) begin
      @(negedge clk);
      if (res_valid) res_q.push_back(res_data);
      if (prev_ready && !op_ready) begin
        acc_t.push_back(c);
        op_num = 32'h4110_0000;
      end
      prev_ready = op_ready;
      if (res_q.size() == 2) op_valid = 1'b0;
    end
    check("b2b_results", 32'(res_q.size()), 32'd2);
    check("b2b_accepts", 32'(acc_t.size()), 32'd2);
    if (res_q.size() == 2) begin
      check("b2b_res0", res_q[0], 32'h4000_0000);
      check("b2b_res1", res_q[1], 32'h4040_0000);
    end
    if (acc_t.size() == 2) check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd16);
    @(negedge clk);
    check_bit("b2b_idle", op_ready, 1'b1);

    // Abort in ITER_B of iteration 3.
    op_valid = 1'b1;
    op_num   = 32'h4110_0000;
    op_denom = 32'h4040_0000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) op_valid = 1'b0;
    end
    check("abort_in_iter_b", 32'(ctrl_obs), 32'(7'b11_01_010));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_bit("abort_op_ready", op_ready, 1'b1);
    check_bit("abort_busy", busy, 1'b0);
    check("abort_ctrl", 32'(ctrl_obs), 32'h0);
    check("abort_dp_num", dp_num, 32'h0);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      saw_valid |= res_valid;
    end
    check_bit("abort_no_result", saw_valid, 1'b0);

    // Fresh op after abort.
    op_valid = 1'b1;
    op_num   = 32'h3F80_0000;
    op_denom = 32'h3F80_0000;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) op_valid = 1'b0;
      if (res_valid) begin
        lat = c;
        break;
      end
    end
    check("post_abort_latency", 32'(lat), 32'd15);
    check("res_1_div_1", res_data, 32'h3F80_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
